// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Iterative radix-2 multiply/divide unit for the RV32M ops.
//               Shift-add multiply and restoring divide, one iteration per
//               cycle, Width iterations per op, Start/Busy/Valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Flush,
    input  logic [2:0]       Op,
    input  logic [Width-1:0] Data1,
    input  logic [Width-1:0] Data2,
    output logic             Busy,
    output logic             Valid,
    output logic [Width-1:0] Result
);

    localparam int CW = $clog2(Width);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [Width-1:0]   ZERO_W   = '0;
    localparam logic [Width-1:0]   ONES_W   = '1;
    localparam logic [Width-1:0]   MIN_W    = {1'b1, {(Width-1){1'b0}}};
    localparam logic [2*Width-1:0] ZERO_2W  = '0;
    localparam logic [CW-1:0]      CNT_INIT = CW'(Width - 1);
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operation context. For a multiply, lo holds the multiplier and
    // opd the multiplicand; for a divide, lo holds the dividend (becoming the
    // quotient) and opd the divisor. hi is the upper product / remainder.
    logic [2:0]       op_q;
    logic             neg_a;
    logic             neg_b;
    logic [CW-1:0]    count;
    logic [Width-1:0] hi;
    logic [Width-1:0] lo;
    logic [Width-1:0] opd;

    logic             accept;

    // Accept-time decode
    logic             a_signed;
    logic             b_signed;
    logic             sign_a;
    logic             sign_b;
    logic [Width-1:0] mag1;
    logic [Width-1:0] mag2;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic [Width-1:0] special_res;

    // Iteration datapath
    logic [Width:0]   mul_sum;
    logic [Width:0]   div_shift;
    logic             div_ge;
    logic [Width-1:0] div_diff;

    // Sign correction
    logic [2*Width-1:0] prod;
    logic [2*Width-1:0] prod_s;
    logic [Width-1:0]   quo_s;
    logic [Width-1:0]   rem_s;
    logic [Width-1:0]   fix_res;

    // Operand signedness, magnitudes and the RISC-V special divide cases
    always_comb begin
        a_signed = (Op == OP_MULH) || (Op == OP_MULHSU) ||
                   (Op == OP_DIV)  || (Op == OP_REM);
        b_signed = (Op == OP_MULH) || (Op == OP_DIV) || (Op == OP_REM);
        sign_a   = a_signed & Data1[Width-1];
        sign_b   = b_signed & Data2[Width-1];
        // The most-negative value maps onto 2^(Width-1), which still fits
        // in Width unsigned bits.
        mag1     = sign_a ? (ZERO_W - Data1) : Data1;
        mag2     = sign_b ? (ZERO_W - Data2) : Data2;
        div_zero = Op[2] && (Data2 == ZERO_W);
        div_ovf  = ((Op == OP_DIV) || (Op == OP_REM)) &&
                   (Data1 == MIN_W) && (Data2 == ONES_W);
        special  = div_zero || div_ovf;
        // Op[1] distinguishes REM/REMU from DIV/DIVU among divide ops.
        special_res = ZERO_W;
        if (div_zero) begin
            special_res = Op[1] ? Data1 : ONES_W;
        end else if (div_ovf) begin
            special_res = Op[1] ? ZERO_W : MIN_W;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs; Flush overrides everything
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        Busy       = 1'b0;
        Valid      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                Busy = 1'b1;
                if (count == CNT_ZERO) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                Busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                Valid = 1'b1;
                if (Start) begin
                    accept     = 1'b1;
                    state_next = special ? S_DONE : S_CALC;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (Flush) begin
            state_next = S_IDLE;
            accept     = 1'b0;
        end
    end

    // One radix-2 step: shift-add for multiply, trial subtract for divide
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : {1'b0, ZERO_W});
        div_shift = {hi, lo[Width-1]};
        div_ge    = (div_shift >= {1'b0, opd});
        // When the trial subtraction succeeds the difference is below the
        // divisor, so the low Width bits carry the whole remainder.
        div_diff  = div_shift[Width-1:0] - opd;
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        prod    = {hi, lo};
        prod_s  = (neg_a ^ neg_b) ? (ZERO_2W - prod) : prod;
        quo_s   = (neg_a ^ neg_b) ? (ZERO_W - lo) : lo;
        rem_s   = neg_a ? (ZERO_W - hi) : hi;
        fix_res = ZERO_W;
        case (op_q)
            OP_MUL:    fix_res = prod_s[Width-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_res = prod_s[2*Width-1:Width];
            OP_DIV,
            OP_DIVU:   fix_res = quo_s;
            OP_REM,
            OP_REMU:   fix_res = rem_s;
            default:   fix_res = ZERO_W;
        endcase
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 3'b000;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            count  <= CNT_ZERO;
            hi     <= ZERO_W;
            lo     <= ZERO_W;
            opd    <= ZERO_W;
            Result <= ZERO_W;
        end else if (accept) begin
            op_q  <= Op;
            neg_a <= sign_a;
            neg_b <= sign_b;
            count <= CNT_INIT;
            hi    <= ZERO_W;
            if (Op[2]) begin
                lo  <= mag1;
                opd <= mag2;
            end else begin
                lo  <= mag2;
                opd <= mag1;
            end
            // Special divide cases finish straight from accept.
            if (special) begin
                Result <= special_res;
            end
        end else if (state == S_CALC) begin
            if (count != CNT_ZERO) begin
                count <= count - CNT_ONE;
            end
            if (op_q[2]) begin
                hi <= div_ge ? div_diff : div_shift[Width-1:0];
                lo <= {lo[Width-2:0], div_ge};
            end else begin
                hi <= mul_sum[Width:1];
                lo <= {mul_sum[0], lo[Width-1:1]};
            end
        end else if ((state == S_FIX) && !Flush) begin
            Result <= fix_res;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Self-checking bench for alu_muldiv_seq (Width = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Flush;
    logic [2:0]  Op;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic        Busy;
    logic        Valid;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res;

    alu_muldiv_seq #(.Width(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Flush  (Flush),
        .Op     (Op),
        .Data1  (Data1),
        .Data2  (Data2),
        .Busy   (Busy),
        .Valid  (Valid),
        .Result (Result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        logic [63:0] q;
        p = 64'h0;
        q = 64'h0;
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Latency from the request cycle: 1 for resolved-at-accept divides, else 34
    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op[2] && (b == 32'h0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and wait for Valid; with b2b the Start goes out in the
    // current (DONE) cycle instead of the next one.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b, output logic [31:0] res, output int lat,
                          output int bcnt);
        if (!b2b) @(negedge clk);
        Start = 1'b1; Op = op; Data1 = a; Data2 = b;
        @(negedge clk);
        Start = 1'b0; Op = 3'($urandom); Data1 = $urandom; Data2 = $urandom;
        lat  = 1;
        bcnt = 0;
        while (!Valid && lat < 100) begin
            if (Busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = Result;
    endtask

    task automatic op_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit b2b, input logic [31:0] exp,
                            input int exp_lat);
        logic [31:0] res;
        int lat;
        int bcnt;
        run_op(op, a, b, b2b, res, lat, bcnt);
        check({tag, " result"}, res, exp);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(bcnt), 32'((exp_lat == 1) ? 0 : exp_lat - 1));
        last_res = exp;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int lat;
        int vcnt;

        rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'd0; Data1 = 32'h0; Data2 = 32'h0;
        last_res = 32'h0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'h0, Busy}, 32'h0);
        check("reset valid", {31'h0, Valid}, 32'h0);
        check("reset result", Result, 32'h0);
        rst_n = 1'b1;

        // Directed multiplies and divides
        op_check("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 34);
        @(negedge clk);
        check("valid one pulse", {31'h0, Valid}, 32'h0);
        op_check("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 34);
        op_check("mulhsu -1*ffffffff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 34);
        op_check("mulhu ffffffff^2", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 34);
        op_check("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 34);
        op_check("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 34);
        op_check("divu ffffffff/16", 3'd5, 32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 34);
        op_check("remu 100/7", 3'd7, 32'd100, 32'd7, 1'b0, 32'd2, 34);

        // Special divide cases
        op_check("div 5/0", 3'd4, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 1);
        op_check("remu 5/0", 3'd7, 32'd5, 32'd0, 1'b0, 32'd5, 1);
        op_check("div min/-1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1);
        op_check("rem min/-1", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1);
        @(negedge clk);
        check("special valid one pulse", {31'h0, Valid}, 32'h0);

        // Start while Busy is ignored
        @(negedge clk);
        Start = 1'b1; Op = 3'd5; Data1 = 32'd1000; Data2 = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        lat = 1;
        while (!Valid && lat < 100) begin
            Start = (lat == 5);
            if (lat == 5) begin Op = 3'd0; Data1 = 32'd3; Data2 = 32'd3; end
            @(negedge clk);
            lat++;
        end
        Start = 1'b0;
        check("start-in-busy result", Result, 32'd142);
        check("start-in-busy latency", 32'(lat), 32'd34);
        last_res = 32'd142;

        // Back-to-back: next Start issued in the DONE cycle
        op_check("b2b first", 3'd0, 32'd1234, 32'd5678, 1'b0, 32'd7006652, 34);
        op_check("b2b second", 3'd4, 32'hFFFF_FC18, 32'd10, 1'b1, 32'hFFFF_FF9C, 34);
        op_check("b2b special", 3'd5, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 1);

        // Flush in mid-CALC: no Valid, Result untouched
        @(negedge clk);
        Start = 1'b1; Op = 3'd4; Data1 = 32'hFFFF_FC18; Data2 = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("flush busy", {31'h0, Busy}, 32'h0);
        check("flush valid", {31'h0, Valid}, 32'h0);
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (Valid || Busy) vcnt++;
        end
        check("flush no activity", 32'(vcnt), 32'h0);
        check("flush result held", Result, last_res);

        // Flush and Start together: Start dropped
        Start = 1'b1; Flush = 1'b1; Op = 3'd0; Data1 = 32'd2; Data2 = 32'd2;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        check("flush+start busy", {31'h0, Busy}, 32'h0);
        check("flush+start valid", {31'h0, Valid}, 32'h0);
        @(negedge clk);
        check("flush+start result", Result, last_res);

        // Asynchronous reset during a divide
        Start = 1'b1; Op = 3'd4; Data1 = 32'd100; Data2 = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", {31'h0, Busy}, 32'h0);
        check("async reset valid", {31'h0, Valid}, 32'h0);
        check("async reset result", Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op_check("after reset div", 3'd4, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF2, 34);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            op_check($sformatf("rnd%0d op%0d a=%08h b=%08h", i, op, a, b), op, a, b,
                     (i % 4) == 1, model(op, a, b), model_lat(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
